// File: rtl/dmem_resp.sv
// dmem_resp: memory-side responder for the LSU load/store request interface.
//
// A request is taken over a valid/ready handshake, the word array is accessed
// one cycle later with byte/half/word lane masking, and a tagged response
// carrying extended load data (or an error flag) is held until the consumer
// accepts it. One transaction is in flight at a time (IDLE -> ACCESS -> RESP).
//
// Ports:
//   clk_i         clock, all state changes on the rising edge
//   reset_i       synchronous reset, active-low (array contents are kept)
//   req_valid_i   request present
//   req_ready_o   block can accept a request (IDLE and out of reset)
//   req_we_i      1 = store, 0 = load
//   req_funct3_i  RV32I load/store funct3
//   req_addr_i    byte address (DMEM_ADDR_LEN+2 bits)
//   req_wdata_i   store data, right-aligned
//   req_tag_i     request tag, echoed on the response
//   resp_valid_o  response present
//   resp_ready_i  consumer accepts the response
//   resp_rdata_o  extended load data; 0 for stores and errors
//   resp_tag_o    tag of the answered request
//   resp_err_o    misaligned access or illegal funct3
module dmem_resp #(
    parameter int DMEM_ADDR_LEN = 8,
    parameter int TAG_W         = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_we_i,
    input  logic [2:0]               req_funct3_i,
    input  logic [DMEM_ADDR_LEN+1:0] req_addr_i,
    input  logic [31:0]              req_wdata_i,
    input  logic [TAG_W-1:0]         req_tag_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [31:0]              resp_rdata_o,
    output logic [TAG_W-1:0]         resp_tag_o,
    output logic                     resp_err_o
);

    localparam int DEPTH = 1 << DMEM_ADDR_LEN;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                   state_r;
    state_t                   state_s;

    // Captured request
    logic                     we_r;
    logic [2:0]               funct3_r;
    logic [DMEM_ADDR_LEN+1:0] addr_r;
    logic [31:0]              wdata_r;
    logic [TAG_W-1:0]         tag_r;

    // Response registers
    logic [31:0]              rdata_r;
    logic                     err_r;
    logic [TAG_W-1:0]         rtag_r;

    logic [31:0]              mem_r [DEPTH];

    logic [DMEM_ADDR_LEN-1:0] word_idx_s;
    logic [1:0]               lane_s;
    logic [31:0]              rd_word_s;
    logic [31:0]              shifted_s;
    logic                     err_s;
    logic [3:0]               be_s;
    logic [31:0]              wd_s;
    logic [31:0]              ld_s;
    logic [3:0]               be_ok_s;
    logic [31:0]              rdata_next_s;

    assign word_idx_s = addr_r[DMEM_ADDR_LEN+1:2];
    assign lane_s     = addr_r[1:0];
    assign rd_word_s  = mem_r[word_idx_s];
    // Bring the addressed lane down to bit 0 so byte/half loads can slice [7:0]/[15:0].
    assign shifted_s  = rd_word_s >> {lane_s, 3'b000};

    assign req_ready_o  = (state_r == IDLE) && reset_i;
    assign resp_valid_o = (state_r == RESP);
    assign resp_rdata_o = rdata_r;
    assign resp_tag_o   = rtag_r;
    assign resp_err_o   = err_r;

    // An erroring access never writes; stores and errors return zero data.
    assign be_ok_s      = (err_s || !we_r) ? 4'b0000 : be_s;
    assign rdata_next_s = (err_s || we_r) ? 32'h0000_0000 : ld_s;

    // Next-state logic of the request/response sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    state_s = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: state_s = RESP;
            RESP: begin
                if (resp_ready_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Decode funct3/alignment into lane enables, write data and extended load data.
    always_comb begin
        err_s = 1'b0;
        be_s  = 4'b0000;
        wd_s  = 32'h0000_0000;
        ld_s  = 32'h0000_0000;
        case (funct3_r)
            3'b000: begin // SB / LB
                be_s = 4'b0001 << lane_s;
                wd_s = {4{wdata_r[7:0]}};
                ld_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
            end
            3'b001: begin // SH / LH
                err_s = lane_s[0];
                be_s  = lane_s[1] ? 4'b1100 : 4'b0011;
                wd_s  = {2{wdata_r[15:0]}};
                ld_s  = {{16{shifted_s[15]}}, shifted_s[15:0]};
            end
            3'b010: begin // SW / LW
                err_s = (lane_s != 2'b00);
                be_s  = 4'b1111;
                wd_s  = wdata_r;
                ld_s  = rd_word_s;
            end
            3'b100: begin // LBU only; no store form
                err_s = we_r;
                ld_s  = {24'h00_0000, shifted_s[7:0]};
            end
            3'b101: begin // LHU only; no store form
                err_s = we_r | lane_s[0];
                ld_s  = {16'h0000, shifted_s[15:0]};
            end
            default: begin
                err_s = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request capture, only at the accepting edge.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            we_r     <= 1'b0;
            funct3_r <= 3'b000;
            addr_r   <= '0;
            wdata_r  <= 32'h0000_0000;
            tag_r    <= '0;
        end else if (state_r == IDLE && req_valid_i) begin
            we_r     <= req_we_i;
            funct3_r <= req_funct3_i;
            addr_r   <= req_addr_i;
            wdata_r  <= req_wdata_i;
            tag_r    <= req_tag_i;
        end
    end

    // Response registers, loaded at the ACCESS edge and held through RESP.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            rdata_r <= 32'h0000_0000;
            err_r   <= 1'b0;
            rtag_r  <= '0;
        end else if (state_r == ACCESS) begin
            rdata_r <= rdata_next_s;
            err_r   <= err_s;
            rtag_r  <= tag_r;
        end
    end

    // Array write; gated by reset so a store cut off by reset leaves no trace.
    always_ff @(posedge clk_i) begin
        if (reset_i && state_r == ACCESS) begin
            for (int b = 0; b < 4; b++) begin
                if (be_ok_s[b]) begin
                    mem_r[word_idx_s][8*b +: 8] <= wd_s[8*b +: 8];
                end
            end
        end
    end

endmodule
